mem_port_arbiter: RTL and testbench

//  Sits directly downstream of the I-cache (port a) and D-cache (port b) miss paths of the

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three line-sized interfaces around the memory port arbiter:
// the I-cache miss port (i_*), the D-cache miss/writeback port (d_*) and the
// shared physical-memory port (mem_*).
//   slave  : the arbiter's view (takes cache requests, drives memory)
//   master : the surrounding system's view (caches plus memory model)
interface mem_port_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges I-cache and D-cache line requests onto one physical-memory port.
// One transaction at a time; round-robin between the caches on a tie.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: i_* (I-cache), d_* (D-cache), mem_* (memory)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction; sample requests and grant one
// BUSY_I | I-cache read in flight on the memory port
// BUSY_D | D-cache read or writeback in flight on the memory port
// DONE   | one quiet cycle so a served cache can drop or replace its request
module mem_port_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant_d;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    logic              mem_read;
    logic              mem_write;
    logic              i_resp;
    logic              d_resp;
    logic [LINE_W-1:0] i_rdata;
    logic [LINE_W-1:0] d_rdata;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // On a tie the port that did not win last time takes the grant.
    assign grant_d = (state == IDLE) && d_req && (!i_req || !last_grant_d);
    assign grant_i = (state == IDLE) && i_req && !grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_resp) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered copy of the winning request; later changes by the cache
    // do not reach the memory port. d_write dominates d_read (writeback
    // goes out before the refill).
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
            op_wr        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (grant_d) begin
            last_grant_d <= 1'b1;
            op_wr        <= bus.d_write;
            addr_q       <= bus.d_address;
            wdata_q      <= bus.d_wdata;
        end else if (grant_i) begin
            last_grant_d <= 1'b0;
            op_wr        <= 1'b0;
            addr_q       <= bus.i_address;
            wdata_q      <= '0;
        end
    end

    // Memory strobes come from the registered state only; the response
    // and read data pass straight through in the mem_resp cycle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        case (state)
            BUSY_I: begin
                mem_read = 1'b1;
                if (bus.mem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = bus.mem_rdata;
                end
            end
            BUSY_D: begin
                mem_read  = !op_wr;
                mem_write = op_wr;
                if (bus.mem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.i_resp      = i_resp;
    assign bus.i_rdata     = i_rdata;
    assign bus.d_resp      = d_resp;
    assign bus.d_rdata     = d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized cache/memory traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] expected);
        n_checks++;
        if (obs !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expected);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic clear_inputs();
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for a memory strobe; n = negedges waited, -1 when the bound expires.
    task automatic wait_mem(output int n);
        n = -1;
        for (int c = 1; c <= 10 && n < 0; c++) begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            if (bus.mem_read || bus.mem_write) n = c;
        end
    endtask

    task automatic respond(input logic [LINE_W-1:0] data);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = data;
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic t_reset_state();
        check("rst_mem_read",  bus.mem_read,    0);
        check("rst_mem_write", bus.mem_write,   0);
        check("rst_mem_addr",  bus.mem_address, 0);
        check("rst_mem_wdata", bus.mem_wdata,   0);
        check("rst_i_resp",    bus.i_resp,      0);
        check("rst_d_resp",    bus.d_resp,      0);
        check("rst_i_rdata",   bus.i_rdata,     0);
        check("rst_d_rdata",   bus.d_rdata,     0);
    endtask

    task automatic t_single_i_read();
        logic [LINE_W-1:0] a5;
        a5 = {(LINE_W/8){8'hA5}};
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_1000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            check("iread_mem_read",  bus.mem_read,    1);
            check("iread_mem_write", bus.mem_write,   0);
            check("iread_addr",      bus.mem_address, 32'h0000_1000);
            if (c == 3) respond(a5);
            else #1;
            check("iread_i_resp",  bus.i_resp,  (c == 3));
            check("iread_i_rdata", bus.i_rdata, (c == 3) ? a5 : '0);
            check("iread_d_resp",  bus.d_resp,  0);
        end
        bus.i_read = 1'b0;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        #1;
        check("iread_done_rd",   bus.mem_read, 0);
        check("iread_done_resp", bus.i_resp,   0);
    endtask

    task automatic t_d_write_addr_change();
        logic [LINE_W-1:0] wd;
        int n;
        wd = {(LINE_W/16){16'h1234}};
        bus.d_write   = 1'b1;
        bus.d_address = 32'h0000_2040;
        bus.d_wdata   = wd;
        wait_mem(n);
        check("dwr_latency", n, 1);
        check("dwr_mem_write", bus.mem_write, 1);
        check("dwr_mem_read",  bus.mem_read,  0);
        check("dwr_addr",      bus.mem_address, 32'h0000_2040);
        check("dwr_wdata",     bus.mem_wdata, wd);
        bus.d_address = 32'hFFFF_0000;
        bus.d_wdata   = '1;
        @(negedge clk);
        check("dwr_hold_write", bus.mem_write, 1);
        check("dwr_hold_read",  bus.mem_read,  0);
        check("dwr_hold_addr",  bus.mem_address, 32'h0000_2040);
        check("dwr_hold_wdata", bus.mem_wdata, wd);
        respond(rand_line());
        check("dwr_d_resp", bus.d_resp, 1);
        check("dwr_i_resp", bus.i_resp, 0);
        bus.d_write = 1'b0;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        #1;
        check("dwr_done_write", bus.mem_write, 0);
        check("dwr_done_resp",  bus.d_resp,    0);
    endtask

    task automatic t_tie_alternate();
        int n;
        logic want_d;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0100;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0200;
        for (int g = 0; g < 4; g++) begin
            want_d = (g % 2 == 0);
            wait_mem(n);
            check("tie_latency", n, (g == 0) ? 1 : 3);
            check("tie_addr", bus.mem_address, want_d ? 32'h0000_0200 : 32'h0000_0100);
            respond(rand_line());
            check("tie_d_resp", bus.d_resp, want_d);
            check("tie_i_resp", bus.i_resp, !want_d);
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic t_rd_wr_both();
        int n;
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        bus.d_address = 32'h0000_4000;
        bus.d_wdata   = rand_line();
        wait_mem(n);
        check("rdwr_latency", n, 1);
        check("rdwr_mem_write", bus.mem_write, 1);
        check("rdwr_mem_read",  bus.mem_read,  0);
        respond(rand_line());
        check("rdwr_d_resp", bus.d_resp, 1);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic t_reset_mid_txn();
        int n;
        bus.d_write   = 1'b1;
        bus.d_address = 32'h0000_3000;
        bus.d_wdata   = rand_line();
        wait_mem(n);
        check("rmid_latency", n, 1);
        check("rmid_write_before", bus.mem_write, 1);
        rst         = 1'b1;
        bus.d_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_write_after", bus.mem_write, 0);
        check("rmid_read_after",  bus.mem_read,  0);
        respond(rand_line());
        check("rmid_late_d_resp", bus.d_resp, 0);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0500;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0600;
        wait_mem(n);
        check("rmid_tie_latency", n, 1);
        check("rmid_tie_d_first", bus.mem_address, 32'h0000_0600);
        respond(rand_line());
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- randomized traffic ----------------
    // Model: one transaction at a time; after the response cycle the port
    // stays quiet for one cycle, then requests are sampled again. Ties go
    // to the cache not served last (I counts as served last after reset).
    task automatic t_random(input int cycles);
        logic              m_busy;
        int                m_wait;
        int                m_delay;
        logic              m_is_d;
        logic              m_wr;
        logic              m_last_was_i;
        logic [ADDR_W-1:0] m_addr;
        logic [LINE_W-1:0] m_wdata;
        logic              responded;
        logic              spurious;
        logic              exp_i;
        logic              exp_d;
        logic              ir;
        logic              dr;
        logic [LINE_W-1:0] rd;
        int                op;
        int                grants;

        m_busy = 0; m_wait = 0; m_delay = 0; m_is_d = 0; m_wr = 0;
        m_last_was_i = 1; m_addr = '0; m_wdata = '0; grants = 0;

        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            if (m_busy) begin
                check("rnd_mem_read",  bus.mem_read,  !m_wr);
                check("rnd_mem_write", bus.mem_write, m_wr);
                check("rnd_mem_addr",  bus.mem_address, m_addr);
                if (m_wr) check("rnd_mem_wdata", bus.mem_wdata, m_wdata);
            end else begin
                check("rnd_quiet", {bus.mem_read, bus.mem_write}, 0);
            end

            responded = 0;
            spurious  = 0;
            if (m_busy) begin
                if (m_delay == 0) responded = 1;
                else m_delay--;
            end else begin
                spurious = ($urandom_range(0, 7) == 0);
            end
            rd = rand_line();
            bus.mem_resp  = responded | spurious;
            bus.mem_rdata = rd;
            #1;
            exp_i = responded && !m_is_d;
            exp_d = responded && m_is_d;
            check("rnd_i_resp",  bus.i_resp,  exp_i);
            check("rnd_d_resp",  bus.d_resp,  exp_d);
            check("rnd_i_rdata", bus.i_rdata, exp_i ? rd : '0);
            check("rnd_d_rdata", bus.d_rdata, exp_d ? rd : '0);

            if (exp_i) bus.i_read = 1'b0;
            if (exp_d) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end
            if (m_busy && !responded && $urandom_range(0, 1) == 1) begin
                if (m_is_d) begin
                    bus.d_address = $urandom();
                    bus.d_wdata   = rand_line();
                end else begin
                    bus.i_address = $urandom();
                end
            end
            if (!bus.i_read && !exp_i && $urandom_range(0, 2) == 0) begin
                bus.i_read    = 1'b1;
                bus.i_address = $urandom();
            end
            if (!(bus.d_read || bus.d_write) && !exp_d && $urandom_range(0, 2) == 0) begin
                op = $urandom_range(0, 2);
                bus.d_read    = (op != 1);
                bus.d_write   = (op != 0);
                bus.d_address = $urandom();
                bus.d_wdata   = rand_line();
            end

            if (m_busy) begin
                if (responded) begin
                    m_busy = 0;
                    m_wait = 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else begin
                ir = bus.i_read;
                dr = bus.d_read || bus.d_write;
                if (ir || dr) begin
                    if (ir && dr) m_is_d = m_last_was_i;
                    else          m_is_d = dr;
                    m_last_was_i = !m_is_d;
                    m_addr  = m_is_d ? bus.d_address : bus.i_address;
                    m_wr    = m_is_d && bus.d_write;
                    m_wdata = bus.d_wdata;
                    m_delay = $urandom_range(0, 3);
                    m_busy  = 1;
                    grants++;
                end
            end
        end
        check("rnd_some_grants", (grants > 100), 1);
    endtask

    initial begin
        clear_inputs();
        do_reset();
        t_reset_state();
        t_single_i_read();
        do_reset();
        t_d_write_addr_change();
        do_reset();
        t_tie_alternate();
        t_rd_wr_both();
        do_reset();
        t_reset_mid_txn();
        do_reset();
        t_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
